// File: rtl/ft_host_cmd_initiator.sv
// ft_host_cmd_initiator: serializes host requests into FT245 command words and parses device response words.
module ft_host_cmd_initiator #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  output logic        req_ready,
  input  logic [7:0]  req_command,
  input  logic [31:0] req_address,
  input  logic [23:0] req_data_count,
  input  logic [31:0] req_data,
  output logic        req_data_strobe,
  output logic        out_fifo_wr,
  input  logic        out_fifo_full,
  output logic [31:0] out_fifo_data,
  output logic        in_fifo_rd,
  input  logic        in_fifo_empty,
  input  logic [31:0] in_fifo_data,
  output logic [7:0]  rsp_status,
  output logic [31:0] rsp_address,
  output logic [23:0] rsp_data_count,
  output logic [31:0] rsp_data,
  output logic        rsp_data_valid,
  output logic        rsp_done,
  output logic        rsp_timeout,
  output logic        cmd_error
);
  typedef enum logic [2:0] {C_IDLE, C_CMD, C_ADDR, C_DATA, C_WAIT} cstate_t;
  typedef enum logic [2:0] {R_IDLE, R_RD1, R_HDR, R_RD2, R_ADDR, R_RD3, R_DATA} rstate_t;
  cstate_t cst;
  rstate_t rs;
  logic [7:0]  cmd;
  logic [31:0] addr, tcnt;
  logic [23:0] cnt, rem, rrem;
  logic [1:0]  ph;
  logic        fin, bad, cap, done_now, hit;
  logic [3:0]  op, req_op;
  assign op = cmd[3:0];
  assign req_op = req_command[3:0];
  assign bad = req_op > 4'd2 || (req_op == 4'd1 && req_data_count == 24'd0);
  assign cap = rs == R_HDR || rs == R_ADDR || rs == R_DATA;
  assign done_now = fin || (rs == R_HDR && in_fifo_data[31:24] == 8'hFF) ||
                    (rs == R_ADDR && rsp_data_count == 24'd0);
  // a response completing in the same cycle suppresses the timeout
  assign hit = TIMEOUT_CYCLES != 32'd0 && cst == C_WAIT && tcnt + 32'd1 == TIMEOUT_CYCLES && !done_now;
  always_ff @(posedge clk) begin
    if (rst) begin
      cst <= C_IDLE;
      req_ready <= 1'b1;
      req_data_strobe <= 1'b0;
      out_fifo_wr <= 1'b0;
      out_fifo_data <= 32'd0;
      cmd_error <= 1'b0;
      cmd <= 8'd0;
      addr <= 32'd0;
      cnt <= 24'd0;
      rem <= 24'd0;
    end else begin
      out_fifo_wr <= 1'b0;
      req_data_strobe <= 1'b0;
      cmd_error <= 1'b0;
      case (cst)
        C_IDLE: if (req_en) begin
          cmd <= req_command;
          addr <= req_address;
          cnt <= req_data_count;
          cmd_error <= bad;
          req_ready <= bad;
          cst <= bad ? C_IDLE : C_CMD;
        end
        C_CMD: if (!out_fifo_full) begin
          out_fifo_wr <= 1'b1;
          out_fifo_data <= {cmd, cnt};
          cst <= op == 4'd0 ? C_WAIT : C_ADDR;
        end
        C_ADDR: if (!out_fifo_full) begin
          out_fifo_wr <= 1'b1;
          out_fifo_data <= addr;
          rem <= cnt;
          cst <= op == 4'd2 ? C_WAIT : C_DATA;
        end
        C_DATA: if (!out_fifo_full) begin
          out_fifo_wr <= 1'b1;
          out_fifo_data <= req_data;
          req_data_strobe <= 1'b1;
          rem <= rem - 24'd1;
          cst <= rem == 24'd1 ? C_WAIT : C_DATA;
        end
        C_WAIT: if (rsp_done || rsp_timeout) begin
          req_ready <= 1'b1;
          cst <= C_IDLE;
        end
        default: cst <= C_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rs <= R_IDLE;
      ph <= 2'd0;
      fin <= 1'b0;
      tcnt <= 32'd0;
      rrem <= 24'd0;
      in_fifo_rd <= 1'b0;
      rsp_status <= 8'd0;
      rsp_address <= 32'd0;
      rsp_data_count <= 24'd0;
      rsp_data <= 32'd0;
      rsp_data_valid <= 1'b0;
      rsp_done <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      in_fifo_rd <= 1'b0;
      rsp_data_valid <= 1'b0;
      rsp_done <= fin;
      rsp_timeout <= 1'b0;
      fin <= 1'b0;
      tcnt <= (cst != C_WAIT || cap) ? 32'd0 : tcnt + 32'd1;
      if (hit) begin
        rsp_timeout <= 1'b1;
        rs <= R_IDLE;
        ph <= 2'd0;
      end else begin
        case (rs)
          R_IDLE: if (!in_fifo_empty) begin
            in_fifo_rd <= 1'b1;
            ph <= 2'd1;
            rs <= R_RD1;
          end
          // ph: 0 waiting for data, 1 pulse issued, 2 wait cycle done
          R_RD1, R_RD2, R_RD3: if (ph == 2'd2) begin
            ph <= 2'd0;
            rs <= rs == R_RD1 ? R_HDR : rs == R_RD2 ? R_ADDR : R_DATA;
          end else if (ph == 2'd1 || !in_fifo_empty) begin
            in_fifo_rd <= ph == 2'd0;
            ph <= ph + 2'd1;
          end
          R_HDR: begin
            rsp_status <= in_fifo_data[31:24];
            rsp_data_count <= in_fifo_data[23:0];
            rsp_done <= in_fifo_data[31:24] == 8'hFF;
            rs <= in_fifo_data[31:24] == 8'hFF ? R_IDLE : R_RD2;
          end
          R_ADDR: begin
            rsp_address <= in_fifo_data;
            rrem <= rsp_data_count;
            rsp_done <= rsp_data_count == 24'd0;
            rs <= rsp_data_count == 24'd0 ? R_IDLE : R_RD3;
          end
          R_DATA: begin
            rsp_data <= in_fifo_data;
            rsp_data_valid <= 1'b1;
            rrem <= rrem - 24'd1;
            fin <= rrem == 24'd1;
            rs <= rrem == 24'd1 ? R_IDLE : R_RD3;
          end
          default: rs <= R_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ft_host_cmd_initiator.sv
// tb_ft_host_cmd_initiator: directed checks of command serialization and response parsing.
module tb_ft_host_cmd_initiator;
  logic        clk = 0, rst = 1, req_en = 0;
  logic        req_ready, req_data_strobe, out_fifo_wr, out_fifo_full = 0;
  logic [7:0]  req_command = 0;
  logic [31:0] req_address = 0, req_data, out_fifo_data;
  logic [23:0] req_data_count = 0;
  logic        in_fifo_rd, in_fifo_empty;
  logic [31:0] in_fifo_data = 0;
  logic [7:0]  rsp_status;
  logic [31:0] rsp_address, rsp_data;
  logic [23:0] rsp_data_count;
  logic        rsp_data_valid, rsp_done, rsp_timeout, cmd_error;
  logic [31:0] obq[$], rdq[$], inq[$];
  logic [31:0] pdata = 0;
  logic        pend = 0, full_q = 0, rdy_at_to = 1;
  int n_vec = 0, n_err = 0;
  int cyc = 0, nstb = 0, stb_base = 0, ndone = 0, nto = 0, nerr = 0, nbad = 0, t_wr = 0, t_to = 0;

  ft_host_cmd_initiator #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_ready(req_ready),
    .req_command(req_command), .req_address(req_address), .req_data_count(req_data_count),
    .req_data(req_data), .req_data_strobe(req_data_strobe),
    .out_fifo_wr(out_fifo_wr), .out_fifo_full(out_fifo_full), .out_fifo_data(out_fifo_data),
    .in_fifo_rd(in_fifo_rd), .in_fifo_empty(in_fifo_empty), .in_fifo_data(in_fifo_data),
    .rsp_status(rsp_status), .rsp_address(rsp_address), .rsp_data_count(rsp_data_count),
    .rsp_data(rsp_data), .rsp_data_valid(rsp_data_valid), .rsp_done(rsp_done),
    .rsp_timeout(rsp_timeout), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;
  assign in_fifo_empty = inq.size() == 0;
  assign req_data = 32'hD000_0000 + 32'(nstb - stb_base);

  // outbound capture, event counters and an inbound FIFO with 2-cycle read latency
  always @(negedge clk) begin
    cyc++;
    if (out_fifo_wr) begin obq.push_back(out_fifo_data); t_wr = cyc; end
    if (out_fifo_wr && full_q) nbad++;
    full_q = out_fifo_full;
    if (req_data_strobe) nstb++;
    if (rsp_data_valid) rdq.push_back(rsp_data);
    if (rsp_done) ndone++;
    if (rsp_timeout) begin nto++; t_to = cyc; rdy_at_to = req_ready; end
    if (cmd_error) nerr++;
    if (pend) begin in_fifo_data = pdata; pend = 0; end
    if (in_fifo_rd && inq.size() > 0) begin pdata = inq.pop_front(); pend = 1; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] c, input logic [31:0] a, input logic [23:0] n);
    req_command = c; req_address = a; req_data_count = n; req_en = 1;
    tick(1);
    req_en = 0;
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int i = 0; i < 200 && obq.size() < n; i++) tick(1);
    check(tag, obq.size(), n);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 200 && !req_ready; i++) tick(1);
    check(tag, req_ready, 1);
  endtask

  initial begin
    int o0, d0, r0, s0, e0, t0;
    tick(3);
    rst = 0;
    tick(1);
    check("rst_ready", req_ready, 1);
    check("rst_pulses", {out_fifo_wr, req_data_strobe, in_fifo_rd, rsp_data_valid, rsp_done, rsp_timeout, cmd_error}, 0);
    check("rst_data", {out_fifo_data, rsp_status, rsp_data_count}, 0);
    // ping
    o0 = obq.size(); d0 = ndone;
    issue(8'h00, 32'h0, 24'd0);
    wait_out("ping_nwords", o0 + 1);
    check("ping_word", obq[o0], 32'h0000_0000);
    inq.push_back(32'hFF00_0000);
    wait_ready("ping_ready");
    check("ping_status", rsp_status, 8'hFF);
    check("ping_done", ndone - d0, 1);
    // read of two words
    o0 = obq.size(); d0 = ndone; r0 = rdq.size();
    issue(8'h02, 32'h0000_1000, 24'd2);
    wait_out("rd_nwords", o0 + 2);
    check("rd_word0", obq[o0], 32'h0200_0002);
    check("rd_word1", obq[o0 + 1], 32'h0000_1000);
    inq.push_back(32'h0200_0002); inq.push_back(32'h0000_1000);
    inq.push_back(32'hAAAA_0001); inq.push_back(32'hAAAA_0002);
    wait_ready("rd_ready");
    check("rd_nvalid", rdq.size() - r0, 2);
    check("rd_data0", rdq[r0], 32'hAAAA_0001);
    check("rd_data1", rdq[r0 + 1], 32'hAAAA_0002);
    check("rd_done", ndone - d0, 1);
    check("rd_hdr", {rsp_status, rsp_data_count, rsp_address}, {8'h02, 24'd2, 32'h0000_1000});
    // write of three words with backpressure mid-data
    o0 = obq.size(); d0 = ndone; stb_base = nstb; s0 = nstb;
    issue(8'h01, 32'h0000_2000, 24'd3);
    for (int i = 0; i < 100 && nstb == s0; i++) tick(1);
    out_fifo_full = 1;
    tick(5);
    out_fifo_full = 0;
    wait_out("wr_nwords", o0 + 5);
    check("wr_word0", obq[o0], 32'h0100_0003);
    check("wr_word1", obq[o0 + 1], 32'h0000_2000);
    check("wr_data0", obq[o0 + 2], 32'hD000_0000);
    check("wr_data1", obq[o0 + 3], 32'hD000_0001);
    check("wr_data2", obq[o0 + 4], 32'hD000_0002);
    check("wr_strobes", nstb - s0, 3);
    check("wr_while_full", nbad, 0);
    inq.push_back(32'h0100_0000); inq.push_back(32'h0000_2000);
    wait_ready("wr_ready");
    check("wr_done", ndone - d0, 1);
    tick(4);
    check("wr_extra", obq.size(), o0 + 5);
    // rejected requests
    o0 = obq.size(); e0 = nerr;
    issue(8'h07, 32'h0, 24'd1);
    tick(3);
    check("err_cmd", nerr - e0, 1);
    issue(8'h01, 32'h0, 24'd0);
    tick(3);
    check("err_wr0", nerr - e0, 2);
    check("err_nowrite", obq.size(), o0);
    check("err_ready", req_ready, 1);
    // timeout on a read with no response
    o0 = obq.size(); t0 = nto;
    issue(8'h02, 32'h0000_3000, 24'd1);
    wait_out("to_nwords", o0 + 2);
    for (int i = 0; i < 100 && nto == t0; i++) tick(1);
    check("to_pulse", nto - t0, 1);
    check("to_delay", t_to - t_wr, 16);
    check("to_ready_low", rdy_at_to, 0);
    check("to_ready", req_ready, 1);
    // reset in the middle of a four-word write
    o0 = obq.size(); stb_base = nstb; s0 = nstb;
    issue(8'h01, 32'h0000_4000, 24'd4);
    for (int i = 0; i < 100 && nstb == s0; i++) tick(1);
    rst = 1;
    tick(1);
    check("mrst_ready", req_ready, 1);
    check("mrst_pulses", {out_fifo_wr, req_data_strobe, in_fifo_rd, rsp_done, rsp_timeout, cmd_error}, 0);
    check("mrst_data", out_fifo_data, 0);
    rst = 0;
    o0 = obq.size();
    tick(10);
    check("mrst_nowrite", obq.size(), o0);
    check("mrst_idle", req_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
